// File: rtl/video_capture_downscaler.sv
// video_capture_downscaler: 2x2 box-filter downscaler from sync/DE RGB888 video to RGB565 FIFO writes
module video_capture_downscaler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  input  logic        vid_de,
  input  logic [23:0] vid_rgb,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_start_pulse,
  output logic        overflow,
  output logic [9:0]  o_pix_count
);
  localparam int HW = H_ACTIVE / 2;
  localparam int BW = $clog2(HW);
  localparam int LW = $clog2(V_ACTIVE);
  typedef enum logic [1:0] {S_SYNC, S_BLANK, S_LINE, S_DONE} state_t;
  state_t state, state_nx;
  logic vs_q, vs_d, de_q, de_d, fall, take, use_px, go_b;
  logic [23:0] rgb_q, even_pix;
  logic [9:0] pix, pix_nx;
  logic [LW-1:0] line, line_nx;
  logic [BW-1:0] idx;
  logic [26:0] hs, hs_b, rd_b;
  logic [26:0] line_buffer [HW];
  logic [7:0] avg_r, avg_g, avg_b;
  logic unused_hsync;
  assign unused_hsync = vid_hsync;
  assign o_pix_count = pix;
  function automatic logic [8:0] hsum(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
  function automatic logic [7:0] avg(input logic [8:0] a, input logic [8:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 10'd2) >> 2);
  endfunction
  always_ff @(posedge clk) begin
    if (!rst) begin
      {vs_q, vs_d, de_q, de_d} <= '0;
      rgb_q <= '0;
    end else begin
      vs_q <= vid_vsync;
      vs_d <= vs_q;
      de_q <= vid_de;
      de_d <= de_q;
      rgb_q <= vid_rgb;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_SYNC;
      pix <= '0;
      line <= '0;
    end else begin
      state <= state_nx;
      pix <= pix_nx;
      line <= line_nx;
    end
  end
  // vsync falling edge overrides every state, including S_DONE and mid-line
  always_comb begin
    state_nx = state;
    pix_nx = pix;
    line_nx = line;
    if (fall) begin
      state_nx = S_BLANK;
      pix_nx = '0;
      line_nx = '0;
    end else if (state == S_BLANK && de_q && !de_d) begin
      state_nx = S_LINE;
      pix_nx = pix + 10'd1;
    end else if (state == S_LINE) begin
      if (de_q) pix_nx = (pix == 10'h3ff) ? pix : pix + 10'd1;
      else begin
        pix_nx = '0;
        line_nx = line + LW'(1);
        state_nx = (line == LW'(V_ACTIVE - 1)) ? S_DONE : S_BLANK;
      end
    end
  end
  always_comb begin
    fall = vs_d & ~vs_q;
    take = !fall && de_q && (state == S_LINE || (state == S_BLANK && !de_d));
    use_px = take && (pix < 10'(H_ACTIVE));
    idx = pix[BW:1];
    hs = {hsum(even_pix[23:16], rgb_q[23:16]), hsum(even_pix[15:8], rgb_q[15:8]),
          hsum(even_pix[7:0], rgb_q[7:0])};
    avg_r = avg(hs_b[26:18], rd_b[26:18]);
    avg_g = avg(hs_b[17:9], rd_b[17:9]);
    avg_b = avg(hs_b[8:0], rd_b[8:0]);
  end
  // line buffer is never reset: even lines always refill it before odd lines read it
  always_ff @(posedge clk) begin
    if (use_px && pix[0]) begin
      if (!line[0]) line_buffer[idx] <= hs;
      else rd_b <= line_buffer[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      even_pix <= '0;
      hs_b <= '0;
      go_b <= 1'b0;
      wr_en <= 1'b0;
      wr_data <= '0;
      overflow <= 1'b0;
      frame_start_pulse <= 1'b0;
    end else begin
      frame_start_pulse <= fall;
      if (use_px && !pix[0]) even_pix <= rgb_q;
      go_b <= use_px && pix[0] && line[0];
      hs_b <= hs;
      wr_en <= go_b && !fifo_full;
      if (go_b && !fifo_full) wr_data <= {avg_r[7:3], avg_g[7:2], avg_b[7:3]};
      if (go_b && fifo_full) overflow <= 1'b1;
    end
  end
endmodule
